// File: rtl/synth_pkg.sv
// ----------------------------------------------------------------------------
// synth_pkg
// Shared types and constants for the polyphonic synthesizer core:
//   env_state_t : per-voice envelope states
//   wave_t      : global waveform selection (matches the wave_sel encoding)
//   LFSR_SEED / LFSR_TAPS and lfsr_next() for the shared noise source.
// ----------------------------------------------------------------------------
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ATTACK  = 2'b01,
        SUSTAIN = 2'b10,
        RELEASE = 2'b11
    } env_state_t;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        SAW    = 2'b01,
        TRI    = 2'b10,
        NOISE  = 2'b11
    } wave_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/synth_voice.sv
// ----------------------------------------------------------------------------
// synth_voice
// One synthesizer voice: phase accumulator, ADSR-style envelope FSM (no decay)
// and waveshaper. All state advances only on a sample tick while en=1.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   en, tick    : global enable and sample-tick strobe
//   note_on     : key-held level, sampled on the tick
//   phase_inc   : phase increment added per tick
//   wave_sel    : waveform selection
//   noise       : shared noise sample from the top-level LFSR
//   sample      : (wave * env) >> SAMPLE_W
//   active      : envelope state is not IDLE
// ----------------------------------------------------------------------------
module synth_voice
    import synth_pkg::*;
#(
    parameter int SAMPLE_W     = 8,
    parameter int PHASE_W      = 16,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic                tick,
    input  logic                note_on,
    input  logic [PHASE_W-1:0]  phase_inc,
    input  wave_t               wave_sel,
    input  logic [SAMPLE_W-1:0] noise,
    output logic [SAMPLE_W-1:0] sample,
    output logic                active
);

    localparam logic [SAMPLE_W-1:0] ENV_MAX   = '1;
    localparam logic [SAMPLE_W:0]   ENV_MAX_X = {1'b0, ENV_MAX};
    localparam logic [SAMPLE_W:0]   ATT_STEP  = (SAMPLE_W+1)'(ATTACK_STEP);
    localparam logic [SAMPLE_W-1:0] REL_STEP  = SAMPLE_W'(RELEASE_STEP);

    logic [PHASE_W-1:0]    phase;
    logic [SAMPLE_W-1:0]   env, env_nxt, env_dn;
    logic [SAMPLE_W:0]     env_up;
    env_state_t            state, state_nxt;
    logic [SAMPLE_W-1:0]   p, tri_base, wave;
    logic [2*SAMPLE_W-1:0] prod;

    // One extra bit on the way up so saturation at full scale is detectable.
    assign env_up = {1'b0, env} + ATT_STEP;
    assign env_dn = (env > REL_STEP) ? (env - REL_STEP) : '0;

    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        unique case (state)
            IDLE: begin
                env_nxt = '0;
                if (note_on) state_nxt = ATTACK;
            end
            ATTACK: begin
                // A released key wins over the attack step on the same tick.
                if (!note_on) begin
                    env_nxt   = env_dn;
                    state_nxt = (env_dn == '0) ? IDLE : RELEASE;
                end else if (env_up >= ENV_MAX_X) begin
                    env_nxt   = ENV_MAX;
                    state_nxt = SUSTAIN;
                end else begin
                    env_nxt   = env_up[SAMPLE_W-1:0];
                end
            end
            SUSTAIN: begin
                env_nxt = ENV_MAX;
                if (!note_on) begin
                    env_nxt   = env_dn;
                    state_nxt = (env_dn == '0) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                // Re-press resumes the attack from the current level, no step.
                if (note_on) begin
                    state_nxt = ATTACK;
                end else begin
                    env_nxt   = env_dn;
                    state_nxt = (env_dn == '0) ? IDLE : RELEASE;
                end
            end
            default: begin
                state_nxt = IDLE;
                env_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= '0;
            env   <= '0;
            state <= IDLE;
        end else if (en && tick) begin
            phase <= phase + phase_inc;
            env   <= env_nxt;
            state <= state_nxt;
        end
    end

    // Waveshaper works on the top SAMPLE_W phase bits.
    assign p        = phase[PHASE_W-1 -: SAMPLE_W];
    assign tri_base = {p[SAMPLE_W-2:0], 1'b0};

    always_comb begin
        wave = '0;
        unique case (wave_sel)
            SQUARE:  wave = p[SAMPLE_W-1] ? '1 : '0;
            SAW:     wave = p;
            TRI:     wave = p[SAMPLE_W-1] ? ~tri_base : tri_base;
            NOISE:   wave = noise;
            default: wave = '0;
        endcase
    end

    assign prod   = {{SAMPLE_W{1'b0}}, wave} * {{SAMPLE_W{1'b0}}, env};
    assign sample = SAMPLE_W'(prod >> SAMPLE_W);
    assign active = (state != IDLE);

endmodule

// File: rtl/poly_synth_core.sv
// ----------------------------------------------------------------------------
// poly_synth_core
// Polyphonic synthesizer: NUM_VOICES voices sharing a sample-tick divider,
// a noise LFSR, a mixer and a PWM audio output.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   en         : global enable; low freezes all state, forces pwm_o low
//   note_on    : per-voice key-held level
//   phase_inc  : per-voice phase increment, voice i at [i*PHASE_W +: PHASE_W]
//   wave_sel   : 00 square, 01 saw, 10 triangle, 11 noise
//   mix_o      : registered mix, updated the cycle after each tick
//   active_o   : per-voice envelope not IDLE
//   pwm_o      : PWM of mix_o over a SAMPLE_W-bit period
// The noise tap takes the low SAMPLE_W LFSR bits, so SAMPLE_W must be <= 16.
// ----------------------------------------------------------------------------
module poly_synth_core
    import synth_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_W     = 8,
    parameter int PHASE_W      = 16,
    parameter int SAMPLE_DIV   = 256,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          en,
    input  logic [NUM_VOICES-1:0]         note_on,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
    input  logic [1:0]                    wave_sel,
    output logic [SAMPLE_W-1:0]           mix_o,
    output logic [NUM_VOICES-1:0]         active_o,
    output logic                          pwm_o
);

    localparam int SHIFT = $clog2(NUM_VOICES);
    localparam int SUM_W = SAMPLE_W + SHIFT;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [15:0]         lfsr;
    logic [SAMPLE_W-1:0] noise;
    wave_t               wave;
    logic [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
    logic [SUM_W-1:0]    sum;
    logic [SAMPLE_W-1:0] mix_val;
    logic                mix_pend;
    logic [SAMPLE_W-1:0] pwm_cnt, pwm_cmp;
    logic                pwm_q;

    // Sample-tick divider.
    assign tick = en && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Shared noise source, one step per tick.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign noise = lfsr[SAMPLE_W-1:0];
    assign wave  = wave_t'(wave_sel);

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        synth_voice #(
            .SAMPLE_W     (SAMPLE_W),
            .PHASE_W      (PHASE_W),
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_voice (
            .clk       (clk),
            .n_rst     (n_rst),
            .en        (en),
            .tick      (tick),
            .note_on   (note_on[i]),
            .phase_inc (phase_inc[i*PHASE_W +: PHASE_W]),
            .wave_sel  (wave),
            .noise     (noise),
            .sample    (voice_sample[i]),
            .active    (active_o[i])
        );
    end

    // Mixer: the sum is wide enough for all voices at full scale.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum = sum + SUM_W'(voice_sample[i]);
        end
    end

    assign mix_val = SAMPLE_W'(sum >> SHIFT);

    // mix_pend marks that the voices have just stepped; it survives an en=0
    // gap so the post-tick mix is still captured once enable returns.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mix_pend <= 1'b0;
            mix_o    <= '0;
        end else if (en) begin
            mix_pend <= tick;
            if (mix_pend) mix_o <= mix_val;
        end
    end

    // PWM: compare value reloads only at the counter wrap to avoid glitching
    // the duty cycle mid-period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= '0;
            pwm_cmp <= '0;
            pwm_q   <= 1'b0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
            if (pwm_cnt == '1) pwm_cmp <= mix_o;
            pwm_q   <= (pwm_cnt < pwm_cmp);
        end
    end

    assign pwm_o = pwm_q & en;

endmodule

// File: tb/tb_poly_synth_core.sv
// ----------------------------------------------------------------------------
// tb_poly_synth_core
// Self-checking bench: a cycle-level reference model derived from the
// behavioural rules (integers, saturating arithmetic) runs alongside the DUT
// and is compared every cycle; a table of per-tick envelope vectors plus
// hand-written sequences cover reset, enable freeze, re-press and PWM duty.
// ----------------------------------------------------------------------------
module tb_poly_synth_core;

    localparam int NV   = 4;
    localparam int SW   = 8;
    localparam int PW   = 16;
    localparam int DIV  = 4;
    localparam int ATT  = 64;
    localparam int REL  = 32;
    localparam int FULL = (1 << SW) - 1;

    localparam int S_IDLE = 0;
    localparam int S_ATT  = 1;
    localparam int S_SUS  = 2;
    localparam int S_REL  = 3;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              en;
    logic [NV-1:0]     note_on;
    logic [NV*PW-1:0]  phase_inc;
    logic [1:0]        wave_sel;
    logic [SW-1:0]     mix_o;
    logic [NV-1:0]     active_o;
    logic              pwm_o;

    poly_synth_core #(
        .NUM_VOICES   (NV),
        .SAMPLE_W     (SW),
        .PHASE_W      (PW),
        .SAMPLE_DIV   (DIV),
        .ATTACK_STEP  (ATT),
        .RELEASE_STEP (REL)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (en),
        .note_on   (note_on),
        .phase_inc (phase_inc),
        .wave_sel  (wave_sel),
        .mix_o     (mix_o),
        .active_o  (active_o),
        .pwm_o     (pwm_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_div, m_mix, m_pcnt, m_pcmp, m_ticks;
    int          m_phase [NV];
    int          m_env   [NV];
    int          m_st    [NV];
    logic [15:0] m_lfsr;
    bit          m_pend, m_pq;

    typedef struct {
        logic [NV-1:0] note;
        int            mix;
        logic [NV-1:0] act;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void add_vec(input logic [NV-1:0] n, input int m, input logic [NV-1:0] a);
        vec_t v;
        v.note = n;
        v.mix  = m;
        v.act  = a;
        vecs.push_back(v);
    endfunction

    function automatic void model_reset();
        m_div = 0; m_mix = 0; m_pcnt = 0; m_pcmp = 0;
        m_pend = 0; m_pq = 0;
        m_lfsr = 16'hACE1;
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0; m_env[v] = 0; m_st[v] = S_IDLE;
        end
    endfunction

    function automatic int wave_of(input int v);
        int p;
        p = m_phase[v] >> (PW - SW);
        case (wave_sel)
            2'd0:    return (p >= 128) ? FULL : 0;
            2'd1:    return p;
            2'd2:    return (p < 128) ? 2 * p : FULL - 2 * (p - 128);
            default: return int'(m_lfsr) & FULL;
        endcase
    endfunction

    function automatic int calc_mix();
        int s;
        s = 0;
        for (int v = 0; v < NV; v++) s += (wave_of(v) * m_env[v]) >> SW;
        return s >> 2;
    endfunction

    function automatic logic [NV-1:0] model_active();
        logic [NV-1:0] a;
        for (int v = 0; v < NV; v++) a[v] = (m_st[v] != S_IDLE);
        return a;
    endfunction

    function automatic void voice_release(input int v);
        m_env[v] = (m_env[v] > REL) ? m_env[v] - REL : 0;
        m_st[v]  = (m_env[v] == 0) ? S_IDLE : S_REL;
    endfunction

    function automatic void voice_tick(input int v);
        bit k;
        k = note_on[v];
        m_phase[v] = (m_phase[v] + int'(phase_inc[v*PW +: PW])) % (1 << PW);
        case (m_st[v])
            S_IDLE: if (k) m_st[v] = S_ATT;
            S_ATT: begin
                if (!k) voice_release(v);
                else begin
                    m_env[v] = m_env[v] + ATT;
                    if (m_env[v] >= FULL) begin
                        m_env[v] = FULL;
                        m_st[v]  = S_SUS;
                    end
                end
            end
            S_SUS: if (!k) voice_release(v);
            default: begin
                if (k) m_st[v] = S_ATT;
                else   voice_release(v);
            end
        endcase
    endfunction

    // One clock edge of the model, using the inputs visible at that edge.
    function automatic void model_step();
        if (!en) return;
        m_pq = (m_pcnt < m_pcmp);
        if (m_pcnt == FULL) m_pcmp = m_mix;
        m_pcnt = (m_pcnt + 1) % (FULL + 1);
        if (m_pend) begin
            m_mix  = calc_mix();
            m_pend = 0;
        end
        if (m_div == DIV - 1) begin
            m_div = 0;
            for (int v = 0; v < NV; v++) voice_tick(v);
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_pend = 1;
            m_ticks++;
        end else begin
            m_div++;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("mix_o",    int'(mix_o),    m_mix);
        check("active_o", int'(active_o), int'(model_active()));
        check("pwm_o",    int'(pwm_o),    en ? int'(m_pq) : 0);
    endtask

    // Advance to the negedge after mix_o has captured the next tick.
    task automatic wait_mix();
        int start;
        bit seen;
        start = m_ticks;
        seen  = 0;
        for (int i = 0; i < 4 * DIV + 4; i++) begin
            cycle();
            if (m_ticks != start) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick expected one within %0d cycles", 4 * DIV + 4);
        end
        cycle();
    endtask

    initial begin
        int cnt;
        int hold;

        // Square wave, all four voices identical so mix_o equals one voice
        // sample = (255 * env) >> 8.
        add_vec(4'hF,  63, 4'hF); add_vec(4'hF, 127, 4'hF);
        add_vec(4'hF, 191, 4'hF); add_vec(4'hF, 254, 4'hF);
        add_vec(4'hF, 254, 4'hF);
        add_vec(4'h0, 222, 4'hF); add_vec(4'h0, 190, 4'hF);
        add_vec(4'h0, 158, 4'hF); add_vec(4'h0, 126, 4'hF);
        add_vec(4'h0,  94, 4'hF); add_vec(4'h0,  62, 4'hF);
        add_vec(4'h0,  30, 4'hF); add_vec(4'h0,   0, 4'h0);
        add_vec(4'hF,   0, 4'hF); add_vec(4'hF,  63, 4'hF);
        add_vec(4'hF, 127, 4'hF); add_vec(4'hF, 191, 4'hF);
        add_vec(4'hF, 254, 4'hF);
        add_vec(4'h0, 222, 4'hF); add_vec(4'h0, 190, 4'hF);
        add_vec(4'h0, 158, 4'hF); add_vec(4'h0, 126, 4'hF);
        add_vec(4'h0,  94, 4'hF);
        add_vec(4'hF,  94, 4'hF); add_vec(4'hF, 158, 4'hF);
        add_vec(4'hF, 222, 4'hF); add_vec(4'hF, 254, 4'hF);
        add_vec(4'h0, 222, 4'hF); add_vec(4'h0, 190, 4'hF);
        add_vec(4'h0, 158, 4'hF); add_vec(4'h0, 126, 4'hF);
        add_vec(4'h0,  94, 4'hF); add_vec(4'h0,  62, 4'hF);
        add_vec(4'h0,  30, 4'hF); add_vec(4'h0,   0, 4'h0);
        add_vec(4'hF,   0, 4'hF); add_vec(4'hF,  63, 4'hF);
        add_vec(4'hF, 127, 4'hF);

        n_rst     = 1'b0;
        en        = 1'b1;
        note_on   = 4'hF;
        wave_sel  = 2'b00;
        phase_inc = {NV{16'h8000}};
        m_ticks   = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mix",    int'(mix_o),    0);
        check("rst_active", int'(active_o), 0);
        check("rst_pwm",    int'(pwm_o),    0);
        n_rst = 1'b1;

        // First tick lands on the 4th edge after reset release.
        repeat (3) cycle();
        check("pre_tick_active", int'(active_o), 0);
        cycle();
        check("first_tick_active", int'(active_o), 4'hF);
        cycle();
        check("first_tick_mix", int'(mix_o), 0);
        phase_inc = '0;

        foreach (vecs[i]) begin
            note_on = vecs[i].note;
            wait_mix();
            check($sformatf("vec%0d_mix", i),    int'(mix_o),    vecs[i].mix);
            check($sformatf("vec%0d_active", i), int'(active_o), int'(vecs[i].act));
        end

        // Freeze mid-attack at env=128.
        en = 1'b0;
        repeat (10) begin
            cycle();
            check("frz_mix",    int'(mix_o),    127);
            check("frz_pwm",    int'(pwm_o),    0);
            check("frz_active", int'(active_o), 4'hF);
        end
        en = 1'b1;
        wait_mix();
        check("resume_mix", int'(mix_o), 191);
        wait_mix();
        check("sustain_mix", int'(mix_o), 254);

        // PWM duty with a steady compare of 254.
        repeat (300) cycle();
        cnt = 0;
        repeat (256) begin
            cycle();
            if (pwm_o) cnt++;
        end
        check("pwm_duty", cnt, 254);

        // Reset mid-note: everything clears at once, no release tail.
        @(negedge clk);
        n_rst   = 1'b0;
        note_on = 4'h0;
        #1;
        check("midrst_mix",    int'(mix_o),    0);
        check("midrst_active", int'(active_o), 0);
        check("midrst_pwm",    int'(pwm_o),    0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        wait_mix();
        check("post_rst_active", int'(active_o), 0);
        check("post_rst_mix",    int'(mix_o),    0);

        // Randomized stimulus against the model.
        for (int s = 0; s < 250; s++) begin
            note_on  = NV'($urandom);
            wave_sel = 2'($urandom);
            en       = ($urandom_range(0, 4) != 0);
            for (int v = 0; v < NV; v++)
                phase_inc[v*PW +: PW] = ($urandom_range(0, 3) == 0) ? '0 : PW'($urandom);
            hold = $urandom_range(1, 40);
            repeat (hold) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_synth_core.md
POLY_SYNTH_CORE -- requirements
Module: poly_synth_core

Interface
REQ-001 Parameter NUM_VOICES, 4: number of independent voices (1..8).
REQ-002 Parameter SAMPLE_W, 8: sample, envelope and PWM resolution in bits.
REQ-003 Parameter PHASE_W, 16: phase-accumulator width per voice.
REQ-004 Parameter SAMPLE_DIV, 256: clk cycles per sample tick (>=2).
REQ-005 Parameters ATTACK_STEP 16 and RELEASE_STEP 8: envelope increment/decrement per tick.
REQ-006 clk  in  1  system clock; the design uses this one clock only.
REQ-007 n_rst  in  1  reset, asynchronous and active-low.
REQ-008 en  in  1  global enable; low freezes all sequential state except reset.
REQ-009 note_on  in  NUM_VOICES  per-voice key-held level.
REQ-010 phase_inc  in  NUM_VOICES*PHASE_W  per-voice phase increment, voice i at bits [i*PHASE_W +: PHASE_W].
REQ-011 wave_sel  in  2  global waveform: 00 square, 01 saw, 10 triangle, 11 noise.
REQ-012 mix_o  out  SAMPLE_W  registered mixed sample.
REQ-013 active_o  out  NUM_VOICES  voice envelope state is not IDLE.
REQ-014 pwm_o  out  1  PWM audio output.

Function
REQ-015 The tick counter counts 0..SAMPLE_DIV-1 while en=1 and asserts the internal tick in the cycle where it equals SAMPLE_DIV-1, then wraps to 0.
REQ-016 On a tick, each phase increments by phase_inc modulo 2^PHASE_W; phase_inc=0 holds the phase.
REQ-017 Waveform value p = top SAMPLE_W phase bits: square = all-ones if MSB=1, else 0; saw = p; triangle = {p[SAMPLE_W-2:0],0} if MSB=0, else its bitwise inverse; noise = low SAMPLE_W bits of a shared 16-bit Fibonacci LFSR (taps 16,14,13,11) advanced once per tick.
REQ-018 Each voice envelope FSM has states IDLE, ATTACK, SUSTAIN, RELEASE and changes only on a tick.
REQ-019 IDLE -> ATTACK when note_on=1; env stays 0 in IDLE.
REQ-020 ATTACK: env += ATTACK_STEP, saturating at 2^SAMPLE_W-1; saturation -> SUSTAIN on the same tick; note_on=0 -> RELEASE, with the release step taking priority over the attack step.
REQ-021 SUSTAIN holds env at maximum; note_on=0 -> RELEASE.
REQ-022 RELEASE: env -= RELEASE_STEP, saturating at 0; reaching 0 -> IDLE; note_on=1 -> ATTACK from the current env with no step applied that tick.
REQ-023 Voice sample = (wave * env) >> SAMPLE_W, unsigned, with a full-precision product.
REQ-024 Mix = (sum of all voice samples) >> clog2(NUM_VOICES), using a sum width of SAMPLE_W+clog2(NUM_VOICES); for NUM_VOICES=1 there is no shift.
REQ-025 mix_o registers Mix in the cycle after a tick, reflecting the post-tick state (latency 1 clk after the tick edge).
REQ-026 The PWM counter is SAMPLE_W bits and free-running while en=1; it loads the compare value from mix_o when it wraps to 0; pwm_o = (counter < compare), registered.
REQ-027 While en=0: tick, phase, env, FSM, LFSR and PWM counters hold; pwm_o is driven 0; mix_o holds.
REQ-028 A note_on change between ticks is sampled only at the tick; pulses shorter than SAMPLE_DIV cycles that do not span a tick are ignored.

Reset
REQ-029 While n_rst=0: all counters, phases, env=0; FSMs in IDLE; LFSR=16'hACE1; mix_o=0; active_o=0; pwm_o=0.
REQ-030 Reset asserted mid-note aborts every voice immediately with no release tail.

Structure
REQ-031 Package synth_pkg holds the env_state_t enum (IDLE, ATTACK, SUSTAIN, RELEASE), the wave_t enum (SQUARE, SAW, TRI, NOISE) and the LFSR seed/tap constants.
REQ-032 Sub-module synth_voice contains the phase accumulator, the envelope FSM and the waveshaper; it is instantiated NUM_VOICES times by a generate loop. The tick counter, LFSR, mixer and PWM stay in the top level.

Verification (NUM_VOICES=4, SAMPLE_W=8, SAMPLE_DIV=4, ATTACK_STEP=64, RELEASE_STEP=32)
REQ-033 Reset -> mix_o=0, active_o=4'b0000, pwm_o=0; the first tick occurs at cycle 4 after release.
REQ-034 Voice0 note_on=1, saw, phase_inc=16'h1000 -> env sequence 64,128,192,255 then SUSTAIN; phase top byte advances by 16 per tick.
REQ-035 Drop note_on from SUSTAIN -> env sequence 223,191,...,31,0 (8 ticks); active_o[0] falls on the tick that reaches 0.
REQ-036 Square, all voices SUSTAIN, phase MSB=1 -> voice sample 254, mix_o=254; pwm_o high for 254 of 256 cycles.
REQ-037 en=0 for 10 cycles mid-attack (env=128) -> env, phase and mix_o unchanged, pwm_o=0; resume -> next tick gives 192.
REQ-038 note_on re-pressed at env=95 in RELEASE -> that tick gives ATTACK with env 95, next tick 159.
